// File: rtl/game_pkg.sv
// Shared definitions for the tile game: round phase encoding and default
// round timing / score width used by the round controller, gameplay block
// and HEX display mux.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    PLAY      = 2'd2,
    OVER      = 2'd3
  } phase_t;

  localparam int ROUND_SECS_DEF     = 30;
  localparam int COUNTDOWN_SECS_DEF = 3;
  localparam int SCORE_W_DEF        = 9;

  // Widths of the seconds-remaining and countdown-digit displays.
  localparam int TIMER_W = 5;
  localparam int CD_W    = 2;

endpackage

// File: rtl/sat_down_counter.sv
// Loadable down counter that stops at zero. Load has priority over the
// decrement; is_one flags the last tick before the count reaches zero so the
// owner can schedule a phase change on the same edge.
module sat_down_counter #(
  parameter int             W         = 5,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         is_one
);

  // Count register: async reset, load wins, otherwise decrement without wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign is_one = (count == W'(1));

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the tile game, ticking once per second. Walks
// IDLE -> COUNTDOWN -> PLAY -> OVER, gates play through play_en, drives the
// timer and countdown digits and keeps the high score across rounds.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int ROUND_SECS     = ROUND_SECS_DEF,
  parameter int COUNTDOWN_SECS = COUNTDOWN_SECS_DEF,
  parameter int SCORE_W        = SCORE_W_DEF
) (
  input  logic               timer_clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               clear_hs,
  input  logic [SCORE_W-1:0] score,
  output logic [1:0]         phase,
  output logic               play_en,
  output logic [4:0]         timer,
  output logic [1:0]         countdown,
  output logic               game_over,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high
);

  localparam logic [TIMER_W-1:0] ROUND_LOAD = TIMER_W'(ROUND_SECS);
  localparam logic [CD_W-1:0]    CD_LOAD    = CD_W'(COUNTDOWN_SECS);

  phase_t             phase_q, phase_d;
  logic [SCORE_W-1:0] hs_q, hs_d;
  logic               nh_q, nh_d;

  logic               tm_load, tm_en, tm_is_one;
  logic               cd_load, cd_en, cd_is_one;
  logic [TIMER_W-1:0] tm_count;
  logic [CD_W-1:0]    cd_count;

  // Seconds remaining in the round; sits at the full length until PLAY.
  sat_down_counter #(
    .W         (TIMER_W),
    .RESET_VAL (ROUND_LOAD)
  ) u_timer (
    .clk      (timer_clk),
    .reset    (reset),
    .load     (tm_load),
    .en       (tm_en),
    .load_val (ROUND_LOAD),
    .count    (tm_count),
    .is_one   (tm_is_one)
  );

  // Pre-round countdown digit; reaching zero coincides with entering PLAY.
  sat_down_counter #(
    .W         (CD_W),
    .RESET_VAL ('0)
  ) u_countdown (
    .clk      (timer_clk),
    .reset    (reset),
    .load     (cd_load),
    .en       (cd_en),
    .load_val (CD_LOAD),
    .count    (cd_count),
    .is_one   (cd_is_one)
  );

  // Phase, high score and new-high flag registers.
  always_ff @(posedge timer_clk or posedge reset) begin
    if (reset) begin
      phase_q <= IDLE;
      hs_q    <= '0;
      nh_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      hs_q    <= hs_d;
      nh_q    <= nh_d;
    end
  end

  // Next phase, counter controls and high-score commit/clear.
  always_comb begin
    phase_d = phase_q;
    hs_d    = hs_q;
    nh_d    = nh_q;
    tm_load = 1'b0;
    tm_en   = 1'b0;
    cd_load = 1'b0;
    cd_en   = 1'b0;
    unique case (phase_q)
      IDLE: begin
        if (clear_hs) begin
          hs_d = '0;
          nh_d = 1'b0;
        end
        if (start) begin
          phase_d = COUNTDOWN;
          cd_load = 1'b1;
          tm_load = 1'b1;
        end
      end
      COUNTDOWN: begin
        // A paused tick freezes the digit and blocks the hand-off to PLAY.
        if (!pause) begin
          cd_en = 1'b1;
          if (cd_is_one) begin
            phase_d = PLAY;
          end
        end
      end
      PLAY: begin
        if (!pause) begin
          tm_en = 1'b1;
          if (tm_is_one) begin
            phase_d = OVER;
            // Score sampled on the final edge of the round decides the record.
            if (score > hs_q) begin
              hs_d = score;
              nh_d = 1'b1;
            end else begin
              nh_d = 1'b0;
            end
          end
        end
      end
      OVER: begin
        // Clear and restart are independent, so both may land together.
        if (clear_hs) begin
          hs_d = '0;
          nh_d = 1'b0;
        end
        if (start) begin
          phase_d = COUNTDOWN;
          cd_load = 1'b1;
          tm_load = 1'b1;
          nh_d    = 1'b0;
        end
      end
      default: begin
        phase_d = IDLE;
      end
    endcase
  end

  assign phase      = phase_q;
  assign timer      = tm_count;
  assign countdown  = cd_count;
  assign high_score = hs_q;
  assign new_high   = nh_q;
  assign play_en    = (phase_q == PLAY) && !pause;
  assign game_over  = (phase_q == OVER);

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: directed round scenarios followed by random
// start/pause/clear/score traffic, every edge checked against a round model.
module tb_game_round_ctrl;

  localparam int RS = 30;
  localparam int CD = 3;
  localparam int SW = 9;

  logic          timer_clk = 1'b0;
  logic          reset;
  logic          start;
  logic          pause;
  logic          clear_hs;
  logic [SW-1:0] score;
  logic [1:0]    phase;
  logic          play_en;
  logic [4:0]    timer;
  logic [1:0]    countdown;
  logic          game_over;
  logic [SW-1:0] high_score;
  logic          new_high;

  int n_checks = 0;
  int n_err    = 0;

  // Round model state: 0 idle, 1 countdown, 2 play, 3 over.
  int m_phase, m_timer, m_cd, m_hs, m_nh;

  game_round_ctrl #(
    .ROUND_SECS     (RS),
    .COUNTDOWN_SECS (CD),
    .SCORE_W        (SW)
  ) dut (
    .timer_clk  (timer_clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .clear_hs   (clear_hs),
    .score      (score),
    .phase      (phase),
    .play_en    (play_en),
    .timer      (timer),
    .countdown  (countdown),
    .game_over  (game_over),
    .high_score (high_score),
    .new_high   (new_high)
  );

  always #5 timer_clk = ~timer_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_timer = RS;
    m_cd    = 0;
    m_hs    = 0;
    m_nh    = 0;
  endtask

  // One second of game rules applied to the model, using the inputs present at the edge.
  task automatic model_step();
    case (m_phase)
      0: begin
        if (clear_hs) begin m_hs = 0; m_nh = 0; end
        if (start) begin m_phase = 1; m_cd = CD; m_timer = RS; end
      end
      1: begin
        if (!pause) begin
          if (m_cd > 1) m_cd = m_cd - 1;
          else begin m_cd = 0; m_phase = 2; end
        end
      end
      2: begin
        if (!pause) begin
          if (m_timer > 1) m_timer = m_timer - 1;
          else begin
            m_timer = 0;
            m_phase = 3;
            if (int'(score) > m_hs) begin m_hs = int'(score); m_nh = 1; end
            else m_nh = 0;
          end
        end
      end
      default: begin
        if (clear_hs) begin m_hs = 0; m_nh = 0; end
        if (start) begin m_phase = 1; m_cd = CD; m_timer = RS; m_nh = 0; end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("phase", 32'(phase), m_phase);
    chk("timer", 32'(timer), m_timer);
    chk("countdown", 32'(countdown), m_cd);
    chk("high_score", 32'(high_score), m_hs);
    chk("new_high", 32'(new_high), m_nh);
    chk("play_en", 32'(play_en), ((m_phase == 2) && !pause) ? 1 : 0);
    chk("game_over", 32'(game_over), (m_phase == 3) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge timer_clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    pause    = 1'b0;
    clear_hs = 1'b0;
    score    = '0;
    model_reset();
    #12;
    compare_all();
    chk("rst_phase", 32'(phase), 0);
    chk("rst_timer", 32'(timer), RS);
    reset = 1'b0;

    // Round 1: single-tick start, record-setting score of 40.
    score = 9'd40;
    start = 1'b1;
    tick();
    chk("r1_cd3", 32'(countdown), 3);
    start = 1'b0;
    tick();
    chk("r1_cd2", 32'(countdown), 2);
    tick();
    chk("r1_cd1", 32'(countdown), 1);
    tick();
    chk("r1_play_phase", 32'(phase), 2);
    chk("r1_play_timer", 32'(timer), 30);
    repeat (29) tick();
    chk("r1_timer_last", 32'(timer), 1);
    tick();
    chk("r1_over_phase", 32'(phase), 3);
    chk("r1_over_timer", 32'(timer), 0);
    chk("r1_game_over", 32'(game_over), 1);
    chk("r1_hs", 32'(high_score), 40);
    chk("r1_new_high", 32'(new_high), 1);

    // Round 2: pause five ticks at timer 17, clear attempt during PLAY, score 25.
    score = 9'd25;
    start = 1'b1;
    tick();
    chk("r2_restart_cd", 32'(countdown), 3);
    chk("r2_restart_timer", 32'(timer), 30);
    chk("r2_restart_nh", 32'(new_high), 0);
    start = 1'b0;
    repeat (3) tick();
    repeat (13) tick();
    chk("r2_timer17", 32'(timer), 17);
    pause    = 1'b1;
    clear_hs = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("r2_pause_timer", 32'(timer), 17);
      chk("r2_pause_play_en", 32'(play_en), 0);
    end
    chk("r2_clear_in_play", 32'(high_score), 40);
    pause    = 1'b0;
    clear_hs = 1'b0;
    repeat (16) tick();
    chk("r2_still_play", 32'(phase), 2);
    tick();
    chk("r2_over_late", 32'(phase), 3);
    chk("r2_hs_kept", 32'(high_score), 40);
    chk("r2_new_high", 32'(new_high), 0);
    clear_hs = 1'b1;
    tick();
    chk("over_clear_hs", 32'(high_score), 0);
    chk("over_clear_nh", 32'(new_high), 0);
    clear_hs = 1'b0;

    // Round 3: start held throughout; restarts straight out of OVER.
    score = 9'd55;
    start = 1'b1;
    repeat (34) tick();
    chk("r3_over", 32'(phase), 3);
    chk("r3_hs", 32'(high_score), 55);
    tick();
    chk("r3_held_restart_phase", 32'(phase), 1);
    chk("r3_held_restart_cd", 32'(countdown), 3);
    chk("r3_held_restart_timer", 32'(timer), 30);
    start = 1'b0;
    repeat (3) tick();
    repeat (18) tick();
    chk("r4_timer12", 32'(timer), 12);

    // Asynchronous reset between clock edges.
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_phase", 32'(phase), 0);
    chk("async_timer", 32'(timer), 30);
    chk("async_hs", 32'(high_score), 0);
    compare_all();
    #1;
    reset = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 7) == 0);
      pause    = ($urandom_range(0, 5) == 0);
      clear_hs = ($urandom_range(0, 15) == 0);
      score    = SW'($urandom_range(0, 511));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
